// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared defaults and branch-counter encodings for the fetch PC generator
// Contents:
//   XLEN_DEF, RESET_VEC_DEF, STALL_N_DEF, BTB_DEPTH_DEF : default parameters for pc_gen
//   ctr_e    : 2-bit saturating branch counter states (SNT, WNT, WT, ST)
//   ctr_next : saturating counter step toward the resolved direction
package pc_pkg;

  localparam int          XLEN_DEF      = 32;
  localparam logic [31:0] RESET_VEC_DEF = 32'hFFFF_FFFC;
  localparam int          STALL_N_DEF   = 2;
  localparam int          BTB_DEPTH_DEF = 16;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_e;

  function automatic ctr_e ctr_next(input ctr_e c, input logic taken);
    ctr_e n;
    n = c;
    if (taken) begin
      case (c)
        SNT:     n = WNT;
        WNT:     n = WT;
        default: n = ST;
      endcase
    end else begin
      case (c)
        ST:      n = WT;
        WT:      n = WNT;
        default: n = SNT;
      endcase
    end
    return n;
  endfunction

endpackage

// File: rtl/pc_btb.sv
// rtl/pc_btb.sv - direct-mapped branch target buffer with one lookup and one training port
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset (clears all valid bits)
//   i_lk_pc          : PC being fetched
//   o_lk_taken       : entry hits and its counter predicts taken
//   o_lk_target      : stored target of the indexed entry
//   i_upd_valid      : training strobe for a resolved branch/jump
//   i_upd_pc         : PC of the resolved instruction
//   i_upd_taken      : resolved direction
//   i_upd_target     : resolved target
module pc_btb
  import pc_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int DEPTH = BTB_DEPTH_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] i_lk_pc,
  output logic            o_lk_taken,
  output logic [XLEN-1:0] o_lk_target,
  input  logic            i_upd_valid,
  input  logic [XLEN-1:0] i_upd_pc,
  input  logic            i_upd_taken,
  input  logic [XLEN-1:0] i_upd_target
);

  localparam int IW = $clog2(DEPTH);
  localparam int TW = XLEN - IW - 2;

  logic [DEPTH-1:0] r_valid;
  logic [TW-1:0]    r_tag    [DEPTH];
  logic [XLEN-1:0]  r_target [DEPTH];
  ctr_e             r_ctr    [DEPTH];

  logic [IW-1:0] w_lk_idx;
  logic [TW-1:0] w_lk_tag;
  logic          w_lk_hit;
  logic [IW-1:0] w_up_idx;
  logic [TW-1:0] w_up_tag;
  logic          w_up_hit;

  // Instructions are word aligned for indexing; the low PC bits never select an entry.
  logic w_unused_lo;
  assign w_unused_lo = ^{i_lk_pc[1:0], i_upd_pc[1:0]};

  assign w_lk_idx    = i_lk_pc[IW+1:2];
  assign w_lk_tag    = i_lk_pc[XLEN-1:IW+2];
  assign w_lk_hit    = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign o_lk_taken  = w_lk_hit && (r_ctr[w_lk_idx] inside {WT, ST});
  assign o_lk_target = r_target[w_lk_idx];

  assign w_up_idx = i_upd_pc[IW+1:2];
  assign w_up_tag = i_upd_pc[XLEN-1:IW+2];
  assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

  // Only valid bits are reset; a cleared valid masks stale tag/target/counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (i_upd_valid && i_upd_taken) begin
      r_valid[w_up_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && i_upd_valid) begin
      if (w_up_hit) begin
        r_ctr[w_up_idx] <= ctr_next(r_ctr[w_up_idx], i_upd_taken);
        if (i_upd_taken) begin
          r_target[w_up_idx] <= i_upd_target;
        end
      end else if (i_upd_taken) begin
        // Taken miss allocates (evicting any alias); a not-taken miss teaches nothing.
        r_tag[w_up_idx]    <= w_up_tag;
        r_target[w_up_idx] <= i_upd_target;
        r_ctr[w_up_idx]    <= WT;
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch PC generator with flush/redirect/stall priority and optional BTB
// Build option: define PC_GEN_BTB_EN to include the branch target buffer (pc_btb).
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   stall[STALL_N]    : any bit high holds pc (unless flush/redirect)
//   flush_req/pc      : trap redirect, highest priority
//   redirect_req/pc   : EX-stage mispredict correction
//   upd_valid/pc/taken/target : branch training port (ignored without BTB)
//   pc                : registered fetch PC
//   pc_valid          : pc holds a real fetch address
//   pred_taken        : BTB predicts taken for the current pc
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VEC = RESET_VEC_DEF,
  parameter int              STALL_N   = STALL_N_DEF,
  parameter int              BTB_DEPTH = BTB_DEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [STALL_N-1:0] stall,
  input  logic               flush_req,
  input  logic [XLEN-1:0]    flush_pc,
  input  logic               redirect_req,
  input  logic [XLEN-1:0]    redirect_pc,
  input  logic               upd_valid,
  input  logic [XLEN-1:0]    upd_pc,
  input  logic               upd_taken,
  input  logic [XLEN-1:0]    upd_target,
  output logic [XLEN-1:0]    pc,
  output logic               pc_valid,
  output logic               pred_taken
);

  logic [XLEN-1:0] r_pc;
  logic            r_pc_valid;
  logic [XLEN-1:0] w_next_pc;
  logic            w_load;
  logic            w_pred_taken;
  logic [XLEN-1:0] w_pred_target;

`ifdef PC_GEN_BTB_EN
  pc_btb #(
    .XLEN  (XLEN),
    .DEPTH (BTB_DEPTH)
  ) u_btb (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_lk_pc      (r_pc),
    .o_lk_taken   (w_pred_taken),
    .o_lk_target  (w_pred_target),
    .i_upd_valid  (upd_valid),
    .i_upd_pc     (upd_pc),
    .i_upd_taken  (upd_taken),
    .i_upd_target (upd_target)
  );
`else
  logic w_unused_upd;
  assign w_unused_upd  = ^{upd_valid, upd_pc, upd_taken, upd_target, BTB_DEPTH[0]};
  assign w_pred_taken  = 1'b0;
  assign w_pred_target = '0;
`endif

  // Redirects beat stall so a squashed bubble cannot swallow the correction.
  always_comb begin
    w_next_pc = r_pc + XLEN'(4);
    w_load    = 1'b1;
    if (flush_req) begin
      w_next_pc = flush_pc;
    end else if (redirect_req) begin
      w_next_pc = redirect_pc;
    end else if (|stall) begin
      w_next_pc = r_pc;
      w_load    = 1'b0;
    end else if (w_pred_taken) begin
      w_next_pc = w_pred_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc       <= RESET_VEC;
      r_pc_valid <= 1'b0;
    end else if (w_load) begin
      r_pc       <= w_next_pc;
      r_pc_valid <= 1'b1;
    end
  end

  assign pc         = r_pc;
  assign pc_valid   = r_pc_valid;
  assign pred_taken = w_pred_taken;

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - self-checking bench for pc_gen (expectations follow PC_GEN_BTB_EN)
module tb_pc_gen;

`ifdef PC_GEN_BTB_EN
  localparam bit BTB_ON = 1'b1;
`else
  localparam bit BTB_ON = 1'b0;
`endif
  // PC reached after fetching trained 0x40 (taken to 0x100 with BTB, sequential without)
  localparam logic [31:0] AFTER_40 = BTB_ON ? 32'h0000_0100 : 32'h0000_0044;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  stall;
  logic        flush_req, redirect_req, upd_valid, upd_taken;
  logic [31:0] flush_pc, redirect_pc, upd_pc, upd_target;
  logic [31:0] pc;
  logic        pc_valid, pred_taken;

  pc_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .flush_req    (flush_req),
    .flush_pc     (flush_pc),
    .redirect_req (redirect_req),
    .redirect_pc  (redirect_pc),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_taken    (upd_taken),
    .upd_target   (upd_target),
    .pc           (pc),
    .pc_valid     (pc_valid),
    .pred_taken   (pred_taken)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  st;
    logic        fl;
    logic [31:0] fpc;
    logic        rd;
    logic [31:0] rpc;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utg;
    logic [31:0] epc;
    logic        evld;
    logic        epred;
  } step_t;

  typedef struct {
    logic [31:0] pc;
    logic        vld;
    logic        pred;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic step_t mk(input logic [31:0] epc, input logic epred);
    step_t s;
    s = '{rst: 1'b1, st: 2'b00, fl: 1'b0, fpc: '0, rd: 1'b0, rpc: '0,
          uv: 1'b0, upc: '0, ut: 1'b0, utg: '0, epc: epc, evld: 1'b1, epred: epred};
    return s;
  endfunction

  // Drives one cycle of stimulus and records what the DUT must show after the edge.
  task automatic drive(input step_t s);
    rst_n        = s.rst;
    stall        = s.st;
    flush_req    = s.fl;
    flush_pc     = s.fpc;
    redirect_req = s.rd;
    redirect_pc  = s.rpc;
    upd_valid    = s.uv;
    upd_pc       = s.upc;
    upd_taken    = s.ut;
    upd_target   = s.utg;
    sb.push_back('{pc: s.epc, vld: s.evld, pred: s.epred});
  endtask

  task automatic test_reset();
    step_t q[$];
    step_t s;
    exp_t  e;
    s = mk(32'hFFFF_FFFC, 1'b0); s.rst = 1'b0; s.evld = 1'b0; q.push_back(s);
    q.push_back(mk(32'h0000_0000, 1'b0));
    q.push_back(mk(32'h0000_0004, 1'b0));
    q.push_back(mk(32'h0000_0008, 1'b0));
    foreach (q[i]) begin
      drive(q[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (pc !== e.pc) begin errors++; $display("FAIL reset_pc step %0d got %h want %h", i, pc, e.pc); end
      checks++;
      if (pc_valid !== e.vld) begin errors++; $display("FAIL reset_valid step %0d got %b want %b", i, pc_valid, e.vld); end
      checks++;
      if (pred_taken !== e.pred) begin errors++; $display("FAIL reset_pred step %0d got %b want %b", i, pred_taken, e.pred); end
    end
  endtask

  task automatic test_stall_redirect();
    step_t q[$];
    step_t s;
    exp_t  e;
    s = mk(32'h10, 1'b0);  s.rd = 1'b1; s.rpc = 32'h10; q.push_back(s);
    s = mk(32'h10, 1'b0);  s.st = 2'b01; q.push_back(s);
    s = mk(32'h10, 1'b0);  s.st = 2'b01; q.push_back(s);
    s = mk(32'h200, 1'b0); s.st = 2'b10; s.rd = 1'b1; s.rpc = 32'h200; q.push_back(s);
    s = mk(32'h200, 1'b0); s.st = 2'b11; q.push_back(s);
    q.push_back(mk(32'h204, 1'b0));
    foreach (q[i]) begin
      drive(q[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (pc !== e.pc) begin errors++; $display("FAIL stall_pc step %0d got %h want %h", i, pc, e.pc); end
      checks++;
      if (pc_valid !== e.vld) begin errors++; $display("FAIL stall_valid step %0d got %b want %b", i, pc_valid, e.vld); end
    end
  endtask

  task automatic test_priority();
    step_t q[$];
    step_t s;
    exp_t  e;
    s = mk(32'h80, 1'b0);   s.fl = 1'b1; s.fpc = 32'h80; s.rd = 1'b1; s.rpc = 32'h200; q.push_back(s);
    s = mk(32'h1000, 1'b0); s.st = 2'b11; s.fl = 1'b1; s.fpc = 32'h1000; q.push_back(s);
    s = mk(32'h203, 1'b0);  s.rd = 1'b1; s.rpc = 32'h203; q.push_back(s);
    q.push_back(mk(32'h207, 1'b0));
    s = mk(32'hFFFF_FFFC, 1'b0); s.rd = 1'b1; s.rpc = 32'hFFFF_FFFC; q.push_back(s);
    q.push_back(mk(32'h0, 1'b0));
    foreach (q[i]) begin
      drive(q[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (pc !== e.pc) begin errors++; $display("FAIL prio_pc step %0d got %h want %h", i, pc, e.pc); end
    end
  endtask

  task automatic test_btb();
    step_t q[$];
    step_t s;
    exp_t  e;
    // train 0x40 taken -> 0x100 while fetching from 0
    s = mk(32'h4, 1'b0); s.uv = 1'b1; s.upc = 32'h40; s.ut = 1'b1; s.utg = 32'h100; q.push_back(s);
    s = mk(32'h40, BTB_ON); s.rd = 1'b1; s.rpc = 32'h40; q.push_back(s);
    q.push_back(mk(AFTER_40, 1'b0));
    // two not-taken resolutions weaken it below the prediction threshold
    s = mk(AFTER_40 + 32'd4, 1'b0); s.uv = 1'b1; s.upc = 32'h40; q.push_back(s);
    s = mk(AFTER_40 + 32'd8, 1'b0); s.uv = 1'b1; s.upc = 32'h40; q.push_back(s);
    s = mk(32'h40, 1'b0); s.rd = 1'b1; s.rpc = 32'h40; q.push_back(s);
    q.push_back(mk(32'h44, 1'b0));
    // two taken resolutions bring it back to predicting taken
    s = mk(32'h48, 1'b0); s.uv = 1'b1; s.upc = 32'h40; s.ut = 1'b1; s.utg = 32'h100; q.push_back(s);
    s = mk(32'h4C, 1'b0); s.uv = 1'b1; s.upc = 32'h40; s.ut = 1'b1; s.utg = 32'h100; q.push_back(s);
    // 0x80 shares the index with 0x40 but not the tag
    s = mk(32'h80, 1'b0); s.rd = 1'b1; s.rpc = 32'h80; q.push_back(s);
    q.push_back(mk(32'h84, 1'b0));
    s = mk(32'h40, BTB_ON); s.rd = 1'b1; s.rpc = 32'h40; q.push_back(s);
    q.push_back(mk(AFTER_40, 1'b0));
    foreach (q[i]) begin
      drive(q[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (pc !== e.pc) begin errors++; $display("FAIL btb_pc step %0d got %h want %h", i, pc, e.pc); end
      checks++;
      if (pred_taken !== e.pred) begin errors++; $display("FAIL btb_pred step %0d got %b want %b", i, pred_taken, e.pred); end
    end
  endtask

  task automatic test_reset_mid();
    step_t q[$];
    step_t s;
    exp_t  e;
    // reset beats flush and an in-flight taken training of 0x60
    s = mk(32'hFFFF_FFFC, 1'b0); s.rst = 1'b0; s.evld = 1'b0; s.fl = 1'b1; s.fpc = 32'h80;
    s.uv = 1'b1; s.upc = 32'h60; s.ut = 1'b1; s.utg = 32'h300; q.push_back(s);
    s = mk(32'hFFFF_FFFC, 1'b0); s.evld = 1'b0; s.st = 2'b01; q.push_back(s);
    s = mk(32'h40, 1'b0); s.rd = 1'b1; s.rpc = 32'h40; q.push_back(s);
    q.push_back(mk(32'h44, 1'b0));
    s = mk(32'h60, 1'b0); s.rd = 1'b1; s.rpc = 32'h60; q.push_back(s);
    q.push_back(mk(32'h64, 1'b0));
    foreach (q[i]) begin
      drive(q[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (pc !== e.pc) begin errors++; $display("FAIL rstmid_pc step %0d got %h want %h", i, pc, e.pc); end
      checks++;
      if (pc_valid !== e.vld) begin errors++; $display("FAIL rstmid_valid step %0d got %b want %b", i, pc_valid, e.vld); end
      checks++;
      if (pred_taken !== e.pred) begin errors++; $display("FAIL rstmid_pred step %0d got %b want %b", i, pred_taken, e.pred); end
    end
  endtask

  initial begin
    test_reset();
    test_stall_redirect();
    test_priority();
    test_btb();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain got %0d want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
